// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised multi-port register file with bypass,
// pending scoreboard and multi-cycle sweep-clear engine.
module reg_file_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REGS       = 8,
  parameter int NUM_READ_PORTS = 2,
  parameter bit ZERO_REG       = 1'b1,
  parameter bit BYPASS         = 1'b1,
  localparam int AW            = $clog2(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 write_enable,
  input  logic [AW-1:0]                        write_address,
  input  logic [DATA_WIDTH-1:0]                write_data,
  input  logic [NUM_READ_PORTS*AW-1:0]         read_address,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ_PORTS-1:0]            read_pending,
  input  logic                                 mark_enable,
  input  logic [AW-1:0]                        mark_address,
  input  logic                                 clear_req,
  output logic                                 clear_busy,
  output logic                                 clear_done
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [AW-1:0] LAST_INDEX = AW'(NUM_REGS - 1);

  state_t                state, state_next;
  logic [AW-1:0]         index, index_next;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  logic                  sweeping;
  logic                  write_ok;
  logic                  mark_ok;

  // An address is usable when it names a real, writable register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
  endfunction

  assign sweeping = (state == SWEEP);
  assign write_ok = write_enable && !sweeping && addr_ok(write_address);
  assign mark_ok  = mark_enable && !sweeping && addr_ok(mark_address);

  always_comb begin
    state_next = state;
    index_next = index;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = SWEEP;
          index_next = '0;
        end
      end
      SWEEP: begin
        clear_busy = 1'b1;
        index_next = index + AW'(1);
        if (index == LAST_INDEX) begin
          clear_done = 1'b1;
          state_next = IDLE;
          index_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  // A mark and a write to the same register in one cycle leave it pending:
  // the newly issued producer is still outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sweeping) begin
          if (index == AW'(i)) begin
            regs[i]    <= '0;
            pending[i] <= 1'b0;
          end
        end else begin
          if (write_ok && (write_address == AW'(i))) begin
            regs[i]    <= write_data;
            pending[i] <= 1'b0;
          end
          if (mark_ok && (mark_address == AW'(i))) pending[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
    logic [AW-1:0] ra;
    logic          ra_ok;
    logic          fwd;

    assign ra    = read_address[p*AW +: AW];
    assign ra_ok = addr_ok(ra);
    assign fwd   = BYPASS && write_ok && (write_address == ra);

    assign read_data[p*DATA_WIDTH +: DATA_WIDTH] =
      !ra_ok ? '0 : (fwd ? write_data : regs[ra]);
    assign read_pending[p] = ra_ok && !fwd && !sweeping && pending[ra];
  end

endmodule
